serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 1..64).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only when not busy.
REQ-005 SHALL have port sub  input  1  0 = add, 1 = subtract (a - b); captured with start.
REQ-006 SHALL have port a  input  WIDTH  operand A; captured with start.
REQ-007 SHALL have port b  input  WIDTH  operand B; captured with start.
REQ-008 SHALL have port cin  input  1  carry-in for add; captured with start; ignored when sub=1.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a result becomes valid.
REQ-011 SHALL have port sum  output  WIDTH  registered result.
REQ-012 SHALL have port cout  output  1  registered carry-out (for sub: 1 = no borrow).
REQ-013 SHALL have port overflow  output  1  registered signed overflow flag.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE.
REQ-015 IDLE: on start=1, capture a, b, sub and effective carry (sub ? 1 : cin), clear bit counter, go to RUN; otherwise stay.
REQ-016 Subtract SHALL use b inverted bitwise at capture, with carry-in forced to 1.
REQ-017 RUN: each cycle, SHALL add LSB of A shift reg, LSB of B shift reg and carry reg via one full-adder cell, shift both operands right, shift the sum bit into the result register MSB side, and register the new carry.
REQ-018 RUN SHALL last exactly WIDTH cycles; after the WIDTH-th bit, go to DONE.
REQ-019 Latency: with start sampled at edge N, done SHALL be high in the cycle after edge N+WIDTH+1; busy high from edge N+1 until edge N+WIDTH+1.
REQ-020 On entry to DONE, sum SHALL equal the full WIDTH-bit result, cout SHALL equal the final carry, and overflow SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-021 DONE SHALL last one cycle with done=1, busy=0; next state is RUN if start=1 (new capture, back-to-back), otherwise IDLE.
REQ-022 start while in RUN SHALL be ignored with no effect on the operation in flight.
REQ-023 sum, cout and overflow SHALL hold the last completed result until the next DONE; they SHALL NOT show partial results during RUN.
REQ-024 Bit counter width SHALL be $clog2(WIDTH+1); WIDTH=1 SHALL complete in one RUN cycle.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, and clear all internal registers.
REQ-026 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow reset deassertion.
REQ-027 After rst_n rises, the first start SHALL be accepted on the next rising edge.

Structure
REQ-028 Package serial_adder_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the WIDTH default constant.
REQ-029 One sub-module, full_adder_cell (a, b, cin -> sum, cout, combinational), SHALL be instantiated once as the datapath bit slice.

Verification
REQ-030 WIDTH=1 exhaustive: all 8 {a,b,cin} combinations, add -> sum/cout match the full-adder truth table, done 2 cycles after start.
REQ-031 WIDTH=8 add 0xFF+0x01, cin=0 -> sum=0x00, cout=1, overflow=0, done exactly 9 cycles after the start edge.
REQ-032 WIDTH=8 add 0x7F+0x01, cin=0 -> sum=0x80, cout=0, overflow=1; sub 0x05-0x07 -> sum=0xFE, cout=0, overflow=0.
REQ-033 start pulsed again 3 cycles into RUN with different operands -> ignored; result is the first operation's; back-to-back start in DONE yields the second result WIDTH+1 cycles later.
REQ-034 rst_n pulsed low 4 cycles into RUN -> outputs 0 immediately, no done pulse; a fresh 0x10+0x20 afterwards -> sum=0x30.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding
// and the default operand width.
package serial_adder_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder: the single datapath slice reused every RUN cycle by the
// serial adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: operands are shifted LSB-first through one full
// adder cell, one bit per clock, and the result is published on DONE.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
    logic             overflow_q, overflow_d;
    logic             fa_sum, fa_cout;
    logic             capture;

    full_adder_cell u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        // NOTE: every _d starts from its _q so no branch of the case below can infer a latch.
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        ovf_d      = ovf_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;
        // Outputs are registered copies of the state, so they trail it by one cycle.
        busy_d     = (state_q == RUN);
        done_d     = (state_q == DONE);
        capture    = start && ((state_q == IDLE) || (state_q == DONE));

        case (state_q)
            IDLE: begin
                if (capture) state_d = RUN;
            end
            RUN: begin
                a_d            = a_q >> 1;
                b_d            = b_q >> 1;
                res_d          = res_q >> 1;
                res_d[WIDTH-1] = fa_sum;
                carry_d        = fa_cout;
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    ovf_d   = carry_q ^ fa_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                sum_d      = res_q;
                cout_d     = carry_q;
                overflow_d = ovf_q;
                state_d    = capture ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Subtraction is a + ~b + 1, so it is folded into the captured operand.
        if (capture) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub ? 1'b1 : cin;
            cnt_d   = '0;
            res_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            ovf_q      <= ovf_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=1 and WIDTH=8, compared
// against an arithmetic reference model.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, sub1, cin1;
    logic [0:0] a1, b1, sum1;
    logic       busy1, done1, cout1, ovf1;
    logic       start8, sub8, cin8;
    logic [7:0] a8, b8, sum8;
    logic       busy8, done8, cout8, ovf8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
    );

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
    );

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic void model(input int w, input bit s, input longint av, input longint bv,
                                  input bit c, output longint es, output bit ec, output bit eo);
        longint m  = longint'(1) << w;
        longint sa = (av >= m / 2) ? av - m : av;
        longint sb = (bv >= m / 2) ? bv - m : bv;
        longint t;
        longint r;
        if (!s) begin
            t  = av + bv + longint'(c);
            es = t % m;
            ec = (t >= m);
            r  = sa + sb + longint'(c);
        end else begin
            t  = av - bv;
            es = ((t % m) + m) % m;
            ec = (av >= bv);
            r  = sa - sb;
        end
        eo = (r < -(m / 2)) || (r >= m / 2);
    endfunction

    // Launch one operation from a negedge and return the start-to-done latency in cycles.
    task automatic do_op(input bit w1, input bit s, input logic [7:0] av, input logic [7:0] bv,
                         input bit c, output int lat, output bit busy_ok, output bit hold_ok);
        logic [7:0] prev;
        prev = w1 ? {7'd0, sum1} : sum8;
        if (w1) begin
            start1 = 1'b1; sub1 = s; a1 = av[0]; b1 = bv[0]; cin1 = c;
        end else begin
            start8 = 1'b1; sub8 = s; a8 = av; b8 = bv; cin8 = c;
        end
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        start8 = 1'b0;
        lat = -1; busy_ok = 1'b1; hold_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if ((w1 ? done1 : done8) === 1'b1) begin
                lat = k;
                break;
            end
            if ((w1 ? busy1 : busy8) !== 1'b1) busy_ok = 1'b0;
            if ((w1 ? {7'd0, sum1} : sum8) !== prev) hold_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        int lat; bit bok, hok;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
            n_bad++; $display("FAIL reset_w8: got %h exp 000", {busy8, done8, sum8, cout8, ovf8}); end
        n_cmp++; if ({busy1, done1, sum1, cout1, ovf1} !== 5'h00) begin
            n_bad++; $display("FAIL reset_w1: got %h exp 00", {busy1, done1, sum1, cout1, ovf1}); end
        rst_n = 1'b1;
        do_op(1'b0, 1'b0, 8'h01, 8'h02, 1'b0, lat, bok, hok);
        n_cmp++; if (lat !== 9) begin
            n_bad++; $display("FAIL first_start_lat: got %0d exp 9", lat); end
        n_cmp++; if (sum8 !== 8'h03) begin
            n_bad++; $display("FAIL first_start_sum: got %h exp 03", sum8); end
    endtask

    task automatic test_width1_exhaustive();
        int lat; bit bok, hok; longint es; bit ec, eo;
        for (int i = 0; i < 8; i++) begin
            model(1, 1'b0, longint'(i[2]), longint'(i[1]), i[0], es, ec, eo);
            do_op(1'b1, 1'b0, {7'd0, i[2]}, {7'd0, i[1]}, i[0], lat, bok, hok);
            n_cmp++; if (longint'(sum1) !== es || cout1 !== ec || ovf1 !== eo) begin
                n_bad++; $display("FAIL w1_abc%0d: got s=%0d c=%0d v=%0d exp s=%0d c=%0d v=%0d",
                                  i, sum1, cout1, ovf1, es, ec, eo); end
            n_cmp++; if (lat !== 2) begin
                n_bad++; $display("FAIL w1_lat%0d: got %0d exp 2", i, lat); end
        end
    endtask

    task automatic test_directed();
        logic [7:0] ta[3], tb_[3], ts[3];
        bit tsub[3], tc[3], to[3];
        int lat; bit bok, hok;
        ta = '{8'hFF, 8'h7F, 8'h05}; tb_ = '{8'h01, 8'h01, 8'h07}; tsub = '{1'b0, 1'b0, 1'b1};
        ts = '{8'h00, 8'h80, 8'hFE}; tc = '{1'b1, 1'b0, 1'b0}; to = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            do_op(1'b0, tsub[i], ta[i], tb_[i], 1'b0, lat, bok, hok);
            n_cmp++; if (sum8 !== ts[i] || cout8 !== tc[i] || ovf8 !== to[i]) begin
                n_bad++; $display("FAIL dir%0d: got s=%h c=%0d v=%0d exp s=%h c=%0d v=%0d",
                                  i, sum8, cout8, ovf8, ts[i], tc[i], to[i]); end
            n_cmp++; if (lat !== 9) begin
                n_bad++; $display("FAIL dir%0d_lat: got %0d exp 9", i, lat); end
            n_cmp++; if (bok !== 1'b1 || hok !== 1'b1 || busy8 !== 1'b0) begin
                n_bad++; $display("FAIL dir%0d_busy_hold: got busy_ok=%0d hold_ok=%0d busy_at_done=%0d exp 1 1 0",
                                  i, bok, hok, busy8); end
        end
    endtask

    task automatic test_random();
        int lat; bit bok, hok; longint es; bit ec, eo;
        logic [7:0] av, bv; bit s, c;
        for (int i = 0; i < 24; i++) begin
            av = 8'($urandom); bv = 8'($urandom);
            s = 1'($urandom); c = 1'($urandom);
            model(8, s, longint'(av), longint'(bv), c, es, ec, eo);
            do_op(1'b0, s, av, bv, c, lat, bok, hok);
            n_cmp++; if (longint'(sum8) !== es || cout8 !== ec || ovf8 !== eo || lat !== 9) begin
                n_bad++; $display("FAIL rnd%0d %h%s%h cin=%0d: got s=%h c=%0d v=%0d lat=%0d exp s=%h c=%0d v=%0d lat=9",
                                  i, av, s ? "-" : "+", bv, c, sum8, cout8, ovf8, lat, es[7:0], ec, eo); end
        end
    endtask

    task automatic test_start_in_run();
        int lat = -1; int extra = 0;
        start8 = 1'b1; sub8 = 1'b0; a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0;
        @(posedge clk);
        @(negedge clk); start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1; sub8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
        @(negedge clk); start8 = 1'b0;
        for (int k = 4; k <= 40; k++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin lat = k; break; end
        end
        n_cmp++; if (lat !== 9 || sum8 !== 8'h77 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
            n_bad++; $display("FAIL start_in_run: got lat=%0d s=%h c=%0d v=%0d exp lat=9 s=77 c=0 v=0",
                              lat, sum8, cout8, ovf8); end
        repeat (12) begin
            @(negedge clk);
            if (done8 === 1'b1 || busy8 === 1'b1) extra++;
        end
        n_cmp++; if (extra !== 0) begin
            n_bad++; $display("FAIL start_in_run_spurious: got %0d active cycles exp 0", extra); end
    endtask

    task automatic test_back_to_back();
        int lat1 = -1; int lat2 = -1; longint es; bit ec, eo;
        start8 = 1'b1; sub8 = 1'b0; a8 = 8'hA0; b8 = 8'h70; cin8 = 1'b1;
        @(posedge clk);
        @(negedge clk); start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1; sub8 = 1'b1; a8 = 8'h10; b8 = 8'h80; cin8 = 1'b0;
        for (int k = 3; k <= 40; k++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin lat1 = k; break; end
        end
        start8 = 1'b0;
        model(8, 1'b0, 64'hA0, 64'h70, 1'b1, es, ec, eo);
        n_cmp++; if (lat1 !== 9 || longint'(sum8) !== es || cout8 !== ec || ovf8 !== eo) begin
            n_bad++; $display("FAIL b2b_first: got lat=%0d s=%h c=%0d v=%0d exp lat=9 s=%h c=%0d v=%0d",
                              lat1, sum8, cout8, ovf8, es[7:0], ec, eo); end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin lat2 = k; break; end
        end
        model(8, 1'b1, 64'h10, 64'h80, 1'b0, es, ec, eo);
        n_cmp++; if (lat2 !== 9 || longint'(sum8) !== es || cout8 !== ec || ovf8 !== eo) begin
            n_bad++; $display("FAIL b2b_second: got lat=%0d s=%h c=%0d v=%0d exp lat=9 s=%h c=%0d v=%0d",
                              lat2, sum8, cout8, ovf8, es[7:0], ec, eo); end
    endtask

    task automatic test_reset_mid_run();
        int lat; bit bok, hok; int extra = 0;
        start8 = 1'b1; sub8 = 1'b0; a8 = 8'h55; b8 = 8'h22; cin8 = 1'b0;
        @(posedge clk);
        @(negedge clk); start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
            n_bad++; $display("FAIL mid_run_reset: got %h exp 000", {busy8, done8, sum8, cout8, ovf8}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (14) begin
            @(negedge clk);
            if (done8 === 1'b1 || busy8 === 1'b1) extra++;
        end
        n_cmp++; if (extra !== 0) begin
            n_bad++; $display("FAIL mid_run_no_done: got %0d active cycles exp 0", extra); end
        do_op(1'b0, 1'b0, 8'h10, 8'h20, 1'b0, lat, bok, hok);
        n_cmp++; if (sum8 !== 8'h30 || cout8 !== 1'b0 || ovf8 !== 1'b0 || lat !== 9) begin
            n_bad++; $display("FAIL after_reset_op: got s=%h c=%0d v=%0d lat=%0d exp s=30 c=0 v=0 lat=9",
                              sum8, cout8, ovf8, lat); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        test_reset();
        test_width1_exhaustive();
        test_directed();
        test_random();
        test_start_in_run();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
